pulse_capture: RTL and testbench

Memory-mapped input-capture peripheral on the MIPS data bus, the measuring counterpart of the PWM generator. It samples one external digital input and reports two values, both counted in `clk` cycles:
- the width of the most recent active pulse;
- the period between the two most recent active edges.

It uses the same chip-select/read/write slave interface as the timer, GPIO and PWM blocks. It raises a level interrupt when a new measurement is ready.

---
 rtl/pulse_capture.sv | 163 ++++++++++++++++
 tb/tb_pulse_capture.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_capture.sv
// pulse_capture: bus-mapped input-capture peripheral. Measures the width of
// the most recent active pulse on cap_in and the period between the two most
// recent active edges, both in clk cycles, and raises a level interrupt when
// a new measurement is latched.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   CS_N     chip select (active low)
//   RD_N     read strobe (active low)
//   WR_N     write strobe (active low)
//   Addr     byte offset: 0x000 CTRL, 0x004 STATUS, 0x008 WIDTH, 0x00C PERIOD
//   DataIn   write data
//   DataOut  read data (combinational, 0 when not reading)
//   Intr     registered IE & VALID
//   cap_in   asynchronous input under measurement
module pulse_capture #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  input  logic        cap_in
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act, act_q, act_rise;
  logic                   en_q, ie_q, pol_q;
  logic                   valid_q, valid_d, ovr_q, ovr_d;
  logic                   intr_q;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       width_q, period_q;
  logic                   complete;
  logic                   wr, wr_ctrl, wr_stat, rd;
  logic                   unused_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  assign act      = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign act_rise = act & ~act_q;

  assign wr      = ~CS_N & ~WR_N;
  assign rd      = ~CS_N & ~RD_N;
  assign wr_ctrl = wr && (Addr == 12'h000);
  assign wr_stat = wr && (Addr == 12'h004);

  assign unused_data = ^DataIn[31:3];

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pcnt_d   = pcnt_q;
    complete = 1'b0;
    if (!en_q) begin
      state_d = IDLE;
      wcnt_d  = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          wcnt_d  = '0;
          pcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          if (act_rise) begin
            wcnt_d  = ONE;
            pcnt_d  = ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          pcnt_d = sat_inc(pcnt_q);
          if (act) wcnt_d = sat_inc(wcnt_q);
          else     state_d = LOW;
        end
        LOW: begin
          pcnt_d = sat_inc(pcnt_q);
          if (act_rise) begin
            complete = 1'b1;
            wcnt_d   = ONE;
            pcnt_d   = ONE;
            state_d  = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion outranks a same-cycle write-1-to-clear; OVR looks only at
  // the VALID value from before this cycle.
  always_comb begin
    valid_d = complete | (valid_q & ~(wr_stat & DataIn[0]));
    ovr_d   = (complete & valid_q) | (ovr_q & ~(wr_stat & DataIn[1]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      act_q    <= 1'b0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      pol_q    <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      intr_q   <= 1'b0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      width_q  <= '0;
      period_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], cap_in};
      act_q   <= act;
      if (wr_ctrl) begin
        en_q  <= DataIn[0];
        ie_q  <= DataIn[1];
        pol_q <= DataIn[2];
      end
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      intr_q  <= ie_q & valid_q;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      if (complete) begin
        width_q  <= wcnt_q;
        period_q <= pcnt_q;
      end
    end
  end

  always_comb begin
    DataOut = '0;
    if (rd) begin
      case (Addr)
        12'h000: DataOut = {29'd0, pol_q, ie_q, en_q};
        12'h004: DataOut = {29'd0, state_q != IDLE, ovr_q, valid_q};
        12'h008: DataOut = 32'(width_q);
        12'h00C: DataOut = 32'(period_q);
        default: DataOut = '0;
      endcase
    end
  end

  assign Intr = intr_q;

endmodule

// File: tb/tb_pulse_capture.sv
module tb_pulse_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        CS_N = 1'b1, RD_N = 1'b1, WR_N = 1'b1;
  logic [11:0] Addr = '0;
  logic [31:0] DataIn = '0;
  logic        cap_in = 1'b0;
  logic [31:0] DataOut, DataOut_s;
  logic        Intr, Intr_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_capture dut (
    .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Intr(Intr), .cap_in(cap_in)
  );

  pulse_capture #(.CNT_W(4), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut_s), .Intr(Intr_s), .cap_in(cap_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
    tick();
    CS_N = 1'b1; WR_N = 1'b1; DataIn = '0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic [31:0] ds);
    CS_N = 1'b0; RD_N = 1'b0; Addr = a;
    #1;
    d  = DataOut;
    ds = DataOut_s;
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  // Disable, settle the input at the given level, clear STATUS, then write CTRL.
  task automatic restart(input logic lvl, input logic [31:0] ctrl);
    bus_write(12'h000, 32'h0);
    cap_in = lvl;
    ticks(4);
    bus_write(12'h004, 32'h3);
    bus_write(12'h000, ctrl);
  endtask

  task automatic test_reset();
    logic [31:0] d, ds;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(12'(i * 4), d, ds);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL reset_reg%0d: got %h want %h", i, d, 32'h0);
      end
    end
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_err++; $display("FAIL reset_intr: got %b want 0", Intr);
    end
    CS_N = 1'b1; RD_N = 1'b0; Addr = 12'h000;
    #1;
    n_cmp++;
    if (DataOut !== 32'h0) begin
      n_err++; $display("FAIL reset_cs_idle: got %h want 0", DataOut);
    end
    RD_N = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] d, ds;
    int found;
    bus_write(12'h000, 32'h3);
    bus_read(12'h000, d, ds);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL ctrl_rb: got %h want %h", d, 32'h3);
    end
    cap_in = 1'b1; ticks(5);
    cap_in = 1'b0; ticks(7);
    cap_in = 1'b1;
    found = 0;
    CS_N = 1'b0; RD_N = 1'b0; Addr = 12'h004;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      if (DataOut[0]) found = k + 1;
    end
    CS_N = 1'b1; RD_N = 1'b1;
    n_cmp++;
    if (found != 3) begin
      n_err++; $display("FAIL valid_latency: got %0d want 3", found);
    end
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_err++; $display("FAIL intr_not_yet: got %b want 0", Intr);
    end
    tick();
    n_cmp++;
    if (Intr !== 1'b1) begin
      n_err++; $display("FAIL intr_after: got %b want 1", Intr);
    end
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (d !== 32'd5) begin
      n_err++; $display("FAIL basic_width: got %0d want 5", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (d !== 32'd12) begin
      n_err++; $display("FAIL basic_period: got %0d want 12", d);
    end
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h5) begin
      n_err++; $display("FAIL basic_status: got %h want 5", d);
    end
    bus_read(12'h010, d, ds);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL unmapped: got %h want 0", d);
    end
    bus_read(12'h408, d, ds);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL alias: got %h want 0", d);
    end
  endtask

  task automatic test_overrun_clear();
    logic [31:0] d, ds;
    tick();
    cap_in = 1'b0; ticks(7);
    cap_in = 1'b1; ticks(5);
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h7) begin
      n_err++; $display("FAIL ovr_status: got %h want 7", d);
    end
    bus_write(12'h004, 32'h3);
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL clr_status: got %h want 4", d);
    end
    tick();
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_err++; $display("FAIL clr_intr: got %b want 0", Intr);
    end
    // Second rise issued so its completion edge coincides with the clear write.
    restart(1'b0, 32'h3);
    cap_in = 1'b1; ticks(2);
    cap_in = 1'b0; ticks(2);
    cap_in = 1'b1; ticks(2);
    bus_write(12'h004, 32'h3);
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h5) begin
      n_err++; $display("FAIL clr_vs_complete: got %h want 5", d);
    end
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (d !== 32'd2) begin
      n_err++; $display("FAIL clr_vs_width: got %0d want 2", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (d !== 32'd4) begin
      n_err++; $display("FAIL clr_vs_period: got %0d want 4", d);
    end
  endtask

  task automatic test_min_pulse();
    logic [31:0] d, ds;
    restart(1'b0, 32'h1);
    cap_in = 1'b1; tick();
    cap_in = 1'b0; tick();
    cap_in = 1'b1; ticks(4);
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (d !== 32'd1) begin
      n_err++; $display("FAIL min_width: got %0d want 1", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (d !== 32'd2) begin
      n_err++; $display("FAIL min_period: got %0d want 2", d);
    end
  endtask

  task automatic test_polarity();
    logic [31:0] d, ds;
    restart(1'b1, 32'h5);
    cap_in = 1'b0; ticks(3);
    cap_in = 1'b1; ticks(9);
    cap_in = 1'b0; ticks(4);
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (d !== 32'd3) begin
      n_err++; $display("FAIL pol_width: got %0d want 3", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (d !== 32'd12) begin
      n_err++; $display("FAIL pol_period: got %0d want 12", d);
    end
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_err++; $display("FAIL pol_intr_masked: got %b want 0", Intr);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d, ds;
    restart(1'b0, 32'h1);
    cap_in = 1'b1; ticks(20);
    cap_in = 1'b0; ticks(10);
    cap_in = 1'b1; ticks(4);
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (ds !== 32'd15) begin
      n_err++; $display("FAIL sat_width: got %0d want 15", ds);
    end
    n_cmp++;
    if (d !== 32'd20) begin
      n_err++; $display("FAIL wide_width: got %0d want 20", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (ds !== 32'd15) begin
      n_err++; $display("FAIL sat_period: got %0d want 15", ds);
    end
    n_cmp++;
    if (d !== 32'd30) begin
      n_err++; $display("FAIL wide_period: got %0d want 30", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d, ds;
    restart(1'b0, 32'h1);
    cap_in = 1'b1; ticks(5);
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL abort_busy: got %h want 4", d);
    end
    bus_write(12'h000, 32'h0);
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL abort_busy_hold: got %h want 4", d);
    end
    tick();
    bus_read(12'h004, d, ds);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL abort_idle: got %h want 0", d);
    end
    bus_read(12'h008, d, ds);
    n_cmp++;
    if (d !== 32'd20) begin
      n_err++; $display("FAIL abort_width_kept: got %0d want 20", d);
    end
    bus_read(12'h00C, d, ds);
    n_cmp++;
    if (d !== 32'd30) begin
      n_err++; $display("FAIL abort_period_kept: got %0d want 30", d);
    end
    restart(1'b0, 32'h3);
    cap_in = 1'b1; ticks(6);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(12'(i * 4), d, ds);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL midreset_reg%0d: got %h want 0", i, d);
      end
    end
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_err++; $display("FAIL midreset_intr: got %b want 0", Intr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun_clear();
    test_min_pulse();
    test_polarity();
    test_saturation();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
